// File: rtl/wb_csr_bridge.sv
// Wishbone classic slave to CSR bus bridge. Each Wishbone cycle turns into
// exactly one registered CSR access followed by a single acknowledge.
module wb_csr_bridge #(
  parameter int csr_addr_w = 14,
  parameter int csr_rd_lat = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic [2:0]            wb_cti_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic [csr_addr_w-1:0] csr_a,
  output logic                  csr_we,
  output logic [31:0]           csr_do,
  input  logic [31:0]           csr_di
);

  typedef enum logic [1:0] { IDLE, ADDR, RWAIT, ACK } state_t;

  localparam logic [3:0] rd_wait_init = 4'(csr_rd_lat - 1);

  state_t     state;
  state_t     state_next;
  logic       we_q;
  logic [3:0] cnt;
  logic       req;
  logic       unused_inputs;

  assign req = wb_cyc_i & wb_stb_i;

  // Byte selects, cycle type and address bits outside the CSR word window are don't-cares.
  assign unused_inputs = ^{wb_sel_i, wb_cti_i, wb_adr_i[31:csr_addr_w+2], wb_adr_i[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first, so no path through the case can infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ADDR;
      ADDR:    state_next = we_q ? ACK : RWAIT;
      RWAIT:   if (cnt == 4'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_a    <= '0;
      csr_do   <= '0;
      csr_we   <= 1'b0;
      we_q     <= 1'b0;
      cnt      <= 4'd0;
      wb_dat_o <= '0;
    end else begin
      csr_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            csr_a  <= wb_adr_i[csr_addr_w+1:2];
            csr_do <= wb_dat_i;
            csr_we <= wb_we_i;
            we_q   <= wb_we_i;
          end
        end
        ADDR: begin
          if (!we_q) cnt <= rd_wait_init;
        end
        RWAIT: begin
          // Read data is taken only once the slave latency has fully elapsed.
          if (cnt == 4'd0) wb_dat_o <= csr_di;
          else             cnt      <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // An aborted cycle (cyc dropped) still finishes on the CSR side, but is never acked.
  assign wb_ack_o = (state == ACK) & wb_cyc_i;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Self-checking bench for wb_csr_bridge: two instances (read latency 1 and 3),
// a directed vector table, reset/abort sequences and a randomized run.
module tb_wb_csr_bridge;

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        abort;
    int          gap;
    logic [13:0] exp_a;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic        wb_we;
  logic        cyc    [2];
  logic        stb    [2];
  logic        ack    [2];
  logic [31:0] dat_o  [2];
  logic [13:0] csr_a  [2];
  logic        csr_we [2];
  logic [31:0] csr_do [2];
  logic [31:0] csr_di [2];

  // csr_mem is the CSR slave space seen by the DUTs; ref_mem is what the bench intends it to hold.
  logic [31:0] csr_mem [0:16383];
  logic [31:0] ref_mem [0:16383];

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  wb_csr_bridge #(.csr_addr_w(14), .csr_rd_lat(1)) dut0 (
    .sys_clk (sys_clk),   .sys_rst (sys_rst),
    .wb_adr_i(wb_adr),    .wb_dat_i(wb_dat),    .wb_dat_o(dat_o[0]),
    .wb_sel_i(wb_sel),    .wb_cti_i(wb_cti),    .wb_we_i (wb_we),
    .wb_cyc_i(cyc[0]),    .wb_stb_i(stb[0]),    .wb_ack_o(ack[0]),
    .csr_a   (csr_a[0]),  .csr_we  (csr_we[0]), .csr_do  (csr_do[0]),
    .csr_di  (csr_di[0])
  );

  wb_csr_bridge #(.csr_addr_w(14), .csr_rd_lat(3)) dut1 (
    .sys_clk (sys_clk),   .sys_rst (sys_rst),
    .wb_adr_i(wb_adr),    .wb_dat_i(wb_dat),    .wb_dat_o(dat_o[1]),
    .wb_sel_i(wb_sel),    .wb_cti_i(wb_cti),    .wb_we_i (wb_we),
    .wb_cyc_i(cyc[1]),    .wb_stb_i(stb[1]),    .wb_ack_o(ack[1]),
    .csr_a   (csr_a[1]),  .csr_we  (csr_we[1]), .csr_do  (csr_do[1]),
    .csr_di  (csr_di[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One Wishbone cycle on instance d. Cycle 0 presents the request; the ack is
  // expected in cycle 2 for writes and 2+latency for reads (never when aborted).
  task automatic txn(input int d, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic abort, input logic [13:0] exp_a, input logic [31:0] exp_rdata);
    int          lat   = lat_of(d);
    int          last  = we ? 2 : 2 + lat;
    logic [13:0] a_cap = '0;
    @(posedge sys_clk); #1;
    cyc[1-d] = 1'b0;
    stb[1-d] = 1'b0;
    cyc[d]   = 1'b1;
    stb[d]   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_dat   = dat;
    wb_sel   = 4'($urandom);
    wb_cti   = 3'($urandom);
    csr_di[d] = $urandom;
    @(negedge sys_clk);
    check("c0_ack", 32'(ack[d]), 32'd0);
    check("c0_csr_we", 32'(csr_we[d]), 32'd0);
    for (int n = 1; n <= last; n++) begin
      @(posedge sys_clk); #1;
      if (abort && n == 1) cyc[d] = 1'b0;
      // Only the cycle the slave guarantees carries real data; all others carry a decoy.
      if (!we && n == 1 + lat) csr_di[d] = csr_mem[a_cap];
      else if (n >= 2)         csr_di[d] = ~csr_mem[a_cap];
      else                     csr_di[d] = $urandom;
      @(negedge sys_clk);
      check("ack", 32'(ack[d]), 32'(n == last && !abort));
      check("csr_we", 32'(csr_we[d]), 32'(n == 1 && we));
      if (n == 1) begin
        a_cap = csr_a[d];
        check("csr_a", 32'(csr_a[d]), 32'(exp_a));
        if (we) begin
          check("csr_do", csr_do[d], dat);
          if (csr_we[d]) csr_mem[csr_a[d]] = csr_do[d];
        end
      end
      if (n == last && !we) check("rdata", dat_o[d], exp_rdata);
    end
  endtask

  // Idle cycles with cyc low on both instances; stb is randomly asserted to show it is ignored.
  task automatic idle(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(posedge sys_clk); #1;
      for (int d = 0; d < 2; d++) begin
        cyc[d] = 1'b0;
        stb[d] = 1'($urandom);
      end
      wb_we  = 1'($urandom);
      wb_adr = $urandom;
      wb_dat = $urandom;
      @(negedge sys_clk);
      for (int d = 0; d < 2; d++) begin
        check("idle_ack", 32'(ack[d]), 32'd0);
        check("idle_csr_we", 32'(csr_we[d]), 32'd0);
      end
    end
  endtask

  initial begin
    vec_t tbl [12];
    tbl[0]  = '{0, 1'b1, 32'h6000_0010, 32'hDEAD_BEEF, 1'b0, 1, 14'h0004, 32'h0};
    tbl[1]  = '{0, 1'b0, 32'h6000_0020, 32'h0,         1'b0, 1, 14'h0008, 32'h1234_5678};
    tbl[2]  = '{1, 1'b0, 32'h6000_0030, 32'h0,         1'b0, 1, 14'h000C, 32'hCAFE_F00D};
    tbl[3]  = '{0, 1'b1, 32'h0000_0100, 32'h0BAD_C0DE, 1'b0, 0, 14'h0040, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1, 14'h0040, 32'h0BAD_C0DE};
    tbl[5]  = '{0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 14'h3FFF, 32'h0};
    tbl[6]  = '{0, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 1, 14'h3FFF, 32'hFFFF_FFFF};
    tbl[7]  = '{0, 1'b1, 32'h6000_0044, 32'h1111_2222, 1'b1, 0, 14'h0011, 32'h0};
    tbl[8]  = '{0, 1'b0, 32'h6000_0044, 32'h0,         1'b0, 1, 14'h0011, 32'h1111_2222};
    tbl[9]  = '{1, 1'b1, 32'h0000_0008, 32'h5555_AAAA, 1'b0, 0, 14'h0002, 32'h0};
    tbl[10] = '{1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1, 14'h0002, 32'h5555_AAAA};
    tbl[11] = '{0, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 2, 14'h0000, 32'hA5A5_5A5A};

    sys_rst = 1'b1;
    wb_adr  = '0;
    wb_dat  = '0;
    wb_sel  = '0;
    wb_cti  = '0;
    wb_we   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cyc[d]    = 1'b0;
      stb[d]    = 1'b0;
      csr_di[d] = $urandom;
    end
    for (int i = 0; i < 16384; i++) csr_mem[14'(i)] = $urandom;
    csr_mem[8]  = 32'h1234_5678;
    csr_mem[12] = 32'hCAFE_F00D;
    csr_mem[0]  = 32'hA5A5_5A5A;
    for (int i = 0; i < 16384; i++) ref_mem[14'(i)] = csr_mem[14'(i)];

    // Reset values
    repeat (2) @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", 32'(ack[d]), 32'd0);
      check("rst_csr_we", 32'(csr_we[d]), 32'd0);
      check("rst_csr_a", 32'(csr_a[d]), 32'd0);
      check("rst_csr_do", csr_do[d], 32'd0);
      check("rst_dat_o", dat_o[d], 32'd0);
    end
    sys_rst = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of a write's ADDR cycle
    @(posedge sys_clk); #1;
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    wb_we  = 1'b1;
    wb_adr = 32'h6000_0010;
    wb_dat = 32'hDEAD_BEEF;
    @(posedge sys_clk); #2;
    check("rst_pre_csr_we", 32'(csr_we[0]), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("rst_mid_csr_we", 32'(csr_we[0]), 32'd0);
    check("rst_mid_ack", 32'(ack[0]), 32'd0);
    check("rst_mid_csr_a", 32'(csr_a[0]), 32'd0);
    check("rst_mid_csr_do", csr_do[0], 32'd0);
    check("rst_mid_dat_o", dat_o[0], 32'd0);
    cyc[0] = 1'b0;
    stb[0] = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    idle(3);

    // Directed table: single write/read, latency 3, back-to-back, address extremes, abort
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].d, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].abort, tbl[i].exp_a, tbl[i].exp_rdata);
      if (tbl[i].we) ref_mem[tbl[i].exp_a] = tbl[i].dat;
      if (tbl[i].gap > 0) idle(tbl[i].gap);
    end

    // Randomized traffic against the reference memory, on a small set of CSR words
    for (int i = 0; i < 80; i++) begin
      int          d;
      int          word;
      int          gap;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [13:0] a;
      d    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      we   = 1'($urandom);
      word = $urandom_range(0, 15);
      adr  = $urandom;
      adr[15:2] = 14'(word);
      a    = 14'(word);
      dat  = $urandom;
      txn(d, we, adr, dat, 1'b0, a, ref_mem[a]);
      if (we) ref_mem[a] = dat;
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_csr_bridge.md
# wb_csr_bridge

Wishbone-to-CSR bridge sitting downstream of the shared Wishbone interconnect. It occupies one interconnect slave port and converts classic Wishbone single cycles into transactions on the lightweight CSR bus used by peripheral control registers. All CSR-side outputs are registered. Each Wishbone cycle produces exactly one CSR access and one acknowledge.

## Interface
Parameters:
- csr_addr_w, 14: CSR address width. `csr_a` is taken from `wb_adr_i[csr_addr_w+1:2]`.
- csr_rd_lat, 1: cycles from `csr_a` valid to `csr_di` valid. Legal range is 1..15.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  32  Wishbone byte address.
- wb_dat_i  in  32  Wishbone write data.
- wb_dat_o  out  32  Wishbone read data, registered.
- wb_sel_i  in  4  byte selects. Ignored; all CSR writes are full 32-bit.
- wb_cti_i  in  3  cycle type. Ignored; every access is treated as classic.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- csr_a  out  csr_addr_w  CSR word address, registered.
- csr_we  out  1  CSR write strobe, registered, one-cycle pulse.
- csr_do  out  32  CSR write data, registered.
- csr_di  in  32  CSR read data (OR of all CSR slaves). Valid `csr_rd_lat` cycles after `csr_a`.

## Operation
FSM states: IDLE, ADDR, RWAIT, ACK.
- **IDLE:** when `wb_cyc_i & wb_stb_i` is sampled high:
  - register `csr_a <= wb_adr_i[csr_addr_w+1:2]`, `csr_do <= wb_dat_i`, `csr_we <= wb_we_i`;
  - latch the direction internally;
  - go to ADDR.
- **ADDR:** `csr_a` is driven; `csr_we` is high for this cycle only if the access is a write. Next: ACK for a write, RWAIT for a read. `csr_we` is cleared on leaving ADDR.
- **RWAIT:**
  - A down-counter is loaded with `csr_rd_lat-1` on entry and decrements each cycle.
  - On the cycle the counter reads 0, `wb_dat_o <= csr_di` and the FSM goes to ACK.
- **ACK:** `wb_ack_o = wb_cyc_i` (the state is registered; gating by `cyc` is combinational). Next: IDLE unconditionally.
  - The master's `stb` is still high during ACK but is not resampled, because IDLE is only reached on the following cycle.
- Dropping `wb_cyc_i` mid-transaction does not abort. The CSR access completes, and ack is suppressed if `cyc` is low in ACK.
- `csr_a` and `csr_do` hold their last values while idle. `wb_dat_o` holds its last read value. `csr_we` is 0 outside ADDR.
- Read data is never modified. There is no sign or width conversion; `csr_di` is 32 bits wide.

## Timing
- **Reset:** while `sys_rst` is high, regardless of clock:
  - state = IDLE, counter = 0;
  - `csr_a`, `csr_do`, `wb_dat_o` = 0;
  - `csr_we`, `wb_ack_o` = 0.
- **Reset mid-transaction:** returns to IDLE immediately; no ack is issued; `csr_we` drops asynchronously.
- **Write** (request sampled at edge of cycle 0):
  - cycle 1: ADDR, `csr_we`=1;
  - cycle 2: `wb_ack_o`=1;
  - latency is 2 cycles from request to ack.
- **Read:**
  - cycle 1: ADDR;
  - cycles 2 .. 1+`csr_rd_lat`: RWAIT, with `wb_dat_o` loaded at the end of the last one;
  - cycle 2+`csr_rd_lat`: `wb_ack_o`=1 with `wb_dat_o` valid.
  - With the default latency this is 3 cycles.
- **Throughput:** one access per 3 cycles (writes) or 3+`csr_rd_lat` cycles (reads), including the mandatory IDLE cycle.
- `wb_ack_o` is never high for two consecutive cycles.
- `wb_stb_i` without `wb_cyc_i` is ignored.

## Test plan
- **Reset values:**
  - Stimulus: assert `sys_rst` asynchronously mid-ADDR of a write.
  - Required response: `csr_we` and `wb_ack_o` go to 0 before the next clock edge; all outputs are 0; no ack follows after deassertion.
- **Single write:**
  - Stimulus: `wb_adr_i`=0x6000_0010, `wb_dat_i`=0xDEADBEEF, `we`=1.
  - Required response: `csr_a`=0x0004 with `csr_we`=1 for exactly one cycle (cycle 1); `csr_do`=0xDEADBEEF; `wb_ack_o` pulses in cycle 2.
- **Single read, default latency:**
  - Stimulus: `wb_adr_i`=0x6000_0020; the CSR model returns 0x1234_5678 one cycle after address 0x0008.
  - Required response: `wb_ack_o` is high in cycle 3 only, with `wb_dat_o`=0x1234_5678; `csr_we` stays 0 throughout.
- **Read with `csr_rd_lat`=3:**
  - Required response: ack in cycle 5, with data sampled from `csr_di` in cycle 4.
  - Check: a different value driven on `csr_di` in cycles 2–3 must not appear on `wb_dat_o`.
- **Back-to-back:**
  - Stimulus: master holds `cyc`/`stb` and issues a new request immediately after each ack (write then read).
  - Required response: exactly one `csr_we` pulse and exactly two acks; the second access starts in the cycle after ACK; there are no spurious repeat accesses.
- **Abort:**
  - Stimulus: a write whose `wb_cyc_i` drops in cycle 1.
  - Required response: the `csr_we` pulse still occurs; `wb_ack_o` stays 0; the FSM is back in IDLE by cycle 3.
